// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: default widths, fetch FSM states, FIFO entry layout.
// RESET_PC is shared with the pc block so both ends agree on the first fetch.
package cpu_pkg;

  localparam int CPU_ADDR_W = 32;
  localparam int CPU_DATA_W = 32;

  localparam logic [CPU_ADDR_W-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [CPU_ADDR_W-1:0] pc;
    logic [CPU_DATA_W-1:0] inst;
    logic                  misalign;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; head is read straight from registered storage.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push accepted when not full, or when full with a same-cycle pop; flush wins over both.
module fetch_fifo #(
  parameter  int WIDTH = 65,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && (!full || pop) && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: empty/count gate every use of the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch unit: pc -> imem req/ack -> fetch FIFO -> decode; FETCH_PERF_EN adds stall/flush counters.
// Latency: issue N, ack N+1 at earliest, instruction valid to decode at N+2.
// Backpressure: pcStall_o holds the pc block unless a request issues; decode stalls via instReady_i.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pcStall_o,
  input  logic              branchEnable_i,
  output logic              memReq_o,
  output logic [ADDR_W-1:0] memAddr_o,
  input  logic              memAck_i,
  input  logic [DATA_W-1:0] memData_i,
  output logic              instValid_o,
  input  logic              instReady_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] instPc_o,
  output logic              instMisalign_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       stallCycles_o,
  output logic [31:0]       flushCount_o
`endif
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W + 1;

  fetch_state_t       state_q;
  fetch_state_t       state_d;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  held_addr;
  logic               issue;
  logic               push;
  logic               pop;
  logic               outstanding;
  logic               free_slot;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] push_dat;
  logic [ENTRY_W-1:0] head_dat;

  assign outstanding = (state_q != IDLE);
  assign free_slot   = !fifo_full && ((fifo_count + CNT_W'(outstanding)) < CNT_W'(DEPTH));
  assign held_addr   = {pc_q[ADDR_W-1:2], 2'b00};
  assign push_dat    = {pc_q, memData_i, |pc_q[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (issue) pc_q <= pc_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    push      = 1'b0;
    memReq_o  = 1'b0;
    memAddr_o = '0;
    case (state_q)
      IDLE: begin
        // Ack here belongs to an abandoned request and is ignored.
        if (free_slot && !branchEnable_i) begin
          issue     = 1'b1;
          memReq_o  = 1'b1;
          memAddr_o = {pc_i[ADDR_W-1:2], 2'b00};
          state_d   = WAIT;
        end
      end
      WAIT: begin
        memReq_o  = 1'b1;
        memAddr_o = held_addr;
        if (memAck_i) begin
          push    = !branchEnable_i;
          state_d = IDLE;
        end else if (branchEnable_i) begin
          state_d = DROP;
        end
      end
      DROP: begin
        memReq_o  = 1'b1;
        memAddr_o = held_addr;
        if (memAck_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      issue     = 1'b0;
      push      = 1'b0;
      memReq_o  = 1'b0;
      memAddr_o = '0;
    end
    pcStall_o = !rst && !issue;
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (branchEnable_i),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign instValid_o    = !fifo_empty && !rst;
  assign pop            = instValid_o && instReady_i;
  assign instPc_o       = instValid_o ? head_dat[ENTRY_W-1:DATA_W+1] : '0;
  assign inst_o         = instValid_o ? head_dat[DATA_W:1] : '0;
  assign instMisalign_o = instValid_o && head_dat[0];

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCycles_o <= '0;
      flushCount_o  <= '0;
    end else begin
      if (pcStall_o && (stallCycles_o != 32'hFFFF_FFFF))
        stallCycles_o <= stallCycles_o + 32'd1;
      if (branchEnable_i && (flushCount_o != 32'hFFFF_FFFF))
        flushCount_o <= flushCount_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: reset checks, a directed cycle table, then random traffic against a queue model.
module tb_inst_fetch;
  import cpu_pkg::*;

  localparam int DEPTH = 2;
  localparam int NV    = 26;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pcStall_o;
  logic        branchEnable_i;
  logic        memReq_o;
  logic [31:0] memAddr_o;
  logic        memAck_i;
  logic [31:0] memData_i;
  logic        instValid_o;
  logic        instReady_i;
  logic [31:0] inst_o;
  logic [31:0] instPc_o;
  logic        instMisalign_o;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  always #5 clk = ~clk;

  inst_fetch #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_i           (pc_i),
    .pcStall_o      (pcStall_o),
    .branchEnable_i (branchEnable_i),
    .memReq_o       (memReq_o),
    .memAddr_o      (memAddr_o),
    .memAck_i       (memAck_i),
    .memData_i      (memData_i),
    .instValid_o    (instValid_o),
    .instReady_i    (instReady_i),
    .inst_o         (inst_o),
    .instPc_o       (instPc_o),
    .instMisalign_o (instMisalign_o)
`ifdef FETCH_PERF_EN
    ,
    .stallCycles_o  (stall_cycles),
    .flushCount_o   (flush_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        ack;
    logic        rdy;
    logic        br;
    logic        req;
    logic [31:0] addr;
    logic        stall;
    logic        vld;
    logic [31:0] ipc;
    logic [31:0] inst;
    logic        mis;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] pc, input logic ack, rdy, br, req,
                              input logic [31:0] addr, input logic stall, vld,
                              input logic [31:0] ipc, inst, input logic mis);
    vec_t v;
    v.pc = pc; v.ack = ack; v.rdy = rdy; v.br = br; v.req = req; v.addr = addr;
    v.stall = stall; v.vld = vld; v.ipc = ipc; v.inst = inst; v.mis = mis;
    return v;
  endfunction

  vec_t         tbl [NV];
  fetch_entry_t q[$];
  logic         outst, squash, exp_issue, ack, rdy, br;
  logic [31:0]  out_pc, cur_pc, dat;
  int           age, lat, stall_cnt, flush_cnt, thr;

  initial begin
    //              pc      ack rdy br  req addr   stl vld ipc    inst          mis
    tbl[0]  = mk(32'h000, 0, 1, 0, 1, 32'h000, 0, 0, 32'h000, 32'h0,         0);
    tbl[1]  = mk(32'h004, 1, 1, 0, 1, 32'h000, 1, 0, 32'h000, 32'h0,         0);
    tbl[2]  = mk(32'h004, 0, 1, 0, 1, 32'h004, 0, 1, 32'h000, 32'h1111_0000, 0);
    tbl[3]  = mk(32'h008, 1, 1, 0, 1, 32'h004, 1, 0, 32'h000, 32'h0,         0);
    tbl[4]  = mk(32'h008, 0, 1, 0, 1, 32'h008, 0, 1, 32'h004, 32'h1111_0004, 0);
    tbl[5]  = mk(32'h00C, 1, 1, 0, 1, 32'h008, 1, 0, 32'h000, 32'h0,         0);
    tbl[6]  = mk(32'h00C, 0, 1, 0, 1, 32'h00C, 0, 1, 32'h008, 32'h1111_0008, 0);
    tbl[7]  = mk(32'h010, 1, 0, 0, 1, 32'h00C, 1, 0, 32'h000, 32'h0,         0);
    // misaligned pc: word-aligned request, misalign flag travels with the entry
    tbl[8]  = mk(32'h006, 0, 0, 0, 1, 32'h004, 0, 1, 32'h00C, 32'h1111_000C, 0);
    tbl[9]  = mk(32'h00A, 1, 0, 0, 1, 32'h004, 1, 1, 32'h00C, 32'h1111_000C, 0);
    tbl[10] = mk(32'h00A, 0, 0, 0, 0, 32'h000, 1, 1, 32'h00C, 32'h1111_000C, 0);
    tbl[11] = mk(32'h00A, 0, 1, 0, 0, 32'h000, 1, 1, 32'h00C, 32'h1111_000C, 0);
    tbl[12] = mk(32'h00A, 0, 0, 0, 1, 32'h008, 0, 1, 32'h006, 32'h1111_0004, 1);
    // flush in the same cycle as the ack: no entry, FIFO emptied
    tbl[13] = mk(32'h00C, 1, 0, 1, 1, 32'h008, 1, 1, 32'h006, 32'h1111_0004, 1);
    tbl[14] = mk(32'h100, 0, 1, 0, 1, 32'h100, 0, 0, 32'h000, 32'h0,         0);
    // flush while waiting: request held to its ack, data dropped
    tbl[15] = mk(32'h104, 0, 1, 1, 1, 32'h100, 1, 0, 32'h000, 32'h0,         0);
    tbl[16] = mk(32'h200, 0, 1, 0, 1, 32'h100, 1, 0, 32'h000, 32'h0,         0);
    tbl[17] = mk(32'h200, 1, 1, 0, 1, 32'h100, 1, 0, 32'h000, 32'h0,         0);
    tbl[18] = mk(32'h200, 0, 1, 0, 1, 32'h200, 0, 0, 32'h000, 32'h0,         0);
    tbl[19] = mk(32'h204, 1, 1, 0, 1, 32'h200, 1, 0, 32'h000, 32'h0,         0);
    tbl[20] = mk(32'h204, 0, 1, 0, 1, 32'h204, 0, 1, 32'h200, 32'h1111_0200, 0);
    tbl[21] = mk(32'h208, 1, 1, 0, 1, 32'h204, 1, 0, 32'h000, 32'h0,         0);
    // branch in IDLE with a buffered entry: no request, entry discarded
    tbl[22] = mk(32'h208, 0, 1, 1, 0, 32'h000, 1, 1, 32'h204, 32'h1111_0204, 0);
    tbl[23] = mk(32'h300, 0, 1, 0, 1, 32'h300, 0, 0, 32'h000, 32'h0,         0);
    tbl[24] = mk(32'h304, 1, 1, 0, 1, 32'h300, 1, 0, 32'h000, 32'h0,         0);
    tbl[25] = mk(32'h304, 0, 1, 0, 1, 32'h304, 0, 1, 32'h300, 32'h1111_0300, 0);

    rst = 1'b1; pc_i = '0; branchEnable_i = 1'b0; memAck_i = 1'b0;
    memData_i = '0; instReady_i = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      memAck_i = i[0];
      pc_i = 32'h40;
      #1;
      chk($sformatf("reset%0d memReq", i), memReq_o, 1'b0);
      chk($sformatf("reset%0d instValid", i), instValid_o, 1'b0);
      chk($sformatf("reset%0d pcStall", i), pcStall_o, 1'b0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      pc_i = tbl[i].pc; instReady_i = tbl[i].rdy; branchEnable_i = tbl[i].br;
      memAck_i = tbl[i].ack;
      #1;
      memData_i = 32'h1111_0000 + memAddr_o;
      #1;
      chk($sformatf("vec%0d memReq", i), memReq_o, tbl[i].req);
      chk($sformatf("vec%0d memAddr", i), memAddr_o, tbl[i].addr);
      chk($sformatf("vec%0d pcStall", i), pcStall_o, tbl[i].stall);
      chk($sformatf("vec%0d instValid", i), instValid_o, tbl[i].vld);
      chk($sformatf("vec%0d instPc", i), instPc_o, tbl[i].ipc);
      chk($sformatf("vec%0d inst", i), inst_o, tbl[i].inst);
      chk($sformatf("vec%0d misalign", i), instMisalign_o, tbl[i].mis);
    end

    // Random traffic; reset first abandons the request left open by the table.
    @(negedge clk);
    rst = 1'b1; memAck_i = 1'b1; branchEnable_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    outst = 1'b0; squash = 1'b0; age = 0; lat = 1; out_pc = '0;
    cur_pc = 32'h1000; stall_cnt = 0; flush_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      thr = (cyc / 1000) * 3 + 2;
      rdy = ($urandom_range(0, 9) < thr);
      br  = ($urandom_range(0, 99) < 8);
      exp_issue = !outst && (q.size() < DEPTH) && !br;
      if (outst) ack = (age >= lat);
      else       ack = ($urandom_range(0, 9) == 0);
      dat = $urandom;
      pc_i = cur_pc; instReady_i = rdy; branchEnable_i = br;
      memAck_i = ack; memData_i = dat;
      #1;
      chk("rnd memReq", memReq_o, outst || exp_issue);
      chk("rnd pcStall", pcStall_o, !exp_issue);
      if (exp_issue) chk("rnd issue addr", memAddr_o, cur_pc & ~32'h3);
      if (outst)     chk("rnd held addr", memAddr_o, out_pc & ~32'h3);
      chk("rnd instValid", instValid_o, q.size() != 0);
      if (q.size() != 0) begin
        chk("rnd instPc", instPc_o, q[0].pc);
        chk("rnd inst", inst_o, q[0].inst);
        chk("rnd misalign", instMisalign_o, q[0].misalign);
      end

      if (!exp_issue) stall_cnt++;
      if (br) flush_cnt++;
      if (br) begin
        q.delete();
      end else begin
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (outst && ack && !squash)
          q.push_back('{pc: out_pc, inst: dat, misalign: (out_pc[1:0] != 2'b00)});
      end
      if (outst) begin
        if (ack) outst = 1'b0;
        else begin
          if (br) squash = 1'b1;
          age++;
        end
      end else if (exp_issue) begin
        outst = 1'b1; out_pc = cur_pc; squash = 1'b0; age = 1;
        lat = $urandom_range(1, 3);
      end
      if (exp_issue || br)
        cur_pc = ($urandom & 32'h0000_FFFC) |
                 (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
    end

`ifdef FETCH_PERF_EN
    @(negedge clk);
    chk("stallCycles", stall_cycles, stall_cnt);
    chk("flushCount", flush_count, flush_cnt);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
